// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the register file write port (we3/r3/dw3).
// Accepts completed instructions over a valid/ready handshake and selects the
// result: ALU, PC+4 or load data. It waits for late load data, then extracts,
// extends and aligns it, and issues one registered write per instruction.
// Optional build macro WB_TIMEOUT_EN: when defined, a load that sits in WAIT
// for TIMEOUT cycles without mem_rvalid is aborted. The stage returns to IDLE,
// err pulses and nothing is written.
module wb_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_src,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_off,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            we3,
  output logic [4:0]      r3,
  output logic [XLEN-1:0] dw3,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  state_t state;

  // Pick the addressed lane out of the doubleword, then sign- or zero-extend it
  // according to the load type. Reserved funct3 yields zero; it is flagged
  // elsewhere and never written.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                   input logic [2:0]      off,
                                                   input logic [XLEN-1:0] d);
    logic        [XLEN-1:0] lane;
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [31:0]     sw;
    logic signed [XLEN-1:0] ext;
    lane = d >> {off, 3'b000};
    sb   = lane[7:0];
    sh   = lane[15:0];
    sw   = lane[31:0];
    case (f3)
      3'b000:  ext = XLEN'(sb);
      3'b001:  ext = XLEN'(sh);
      3'b010:  ext = XLEN'(sw);
      3'b011:  ext = d;
      3'b100:  ext = XLEN'(lane[7:0]);
      3'b101:  ext = XLEN'(lane[15:0]);
      3'b110:  ext = XLEN'(lane[31:0]);
      default: ext = '0;
    endcase
    return ext;
  endfunction

  // Misaligned halfword/word/doubleword accesses and the reserved load type
  // are faults; the write is suppressed and err pulses instead.
  function automatic logic load_fault(input logic [2:0] f3,
                                      input logic [2:0] off);
    case (f3)
      3'b001, 3'b101: return off[0];
      3'b010, 3'b110: return |off[1:0];
      3'b011:         return |off;
      3'b111:         return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // ---- stage p0: incoming instruction, handshake and result select ----
  logic            accept_p0;
  logic            acc_load_p0;
  logic            wr_p0;
  logic [XLEN-1:0] res_p0;

  assign in_ready    = (state == IDLE) || (state == COMMIT);
  assign accept_p0   = in_valid && in_ready;
  assign acc_load_p0 = accept_p0 && (in_src == SRC_LOAD);
  assign wr_p0       = (in_rd != 5'd0);
  // Reserved source 11 falls through to the ALU result.
  assign res_p0      = (in_src == SRC_PC4) ? in_pc4 : in_alu;

  // ---- stage p1: latched load context while waiting for memory data ----
  logic [4:0]      ld_rd_p1;
  logic [2:0]      ld_f3_p1;
  logic [2:0]      ld_off_p1;
  logic [XLEN-1:0] ld_data_p1;
  logic            ld_bad_p1;
  logic            ld_wr_p1;

  // Capture the load's destination, type and byte offset when it is accepted.
  always_ff @(posedge clk) begin
    if (acc_load_p0) begin
      ld_rd_p1  <= in_rd;
      ld_f3_p1  <= in_funct3;
      ld_off_p1 <= in_off;
    end
  end

  assign ld_data_p1 = load_extract(ld_f3_p1, ld_off_p1, mem_rdata);
  assign ld_bad_p1  = load_fault(ld_f3_p1, ld_off_p1);
  assign ld_wr_p1   = !ld_bad_p1 && (ld_rd_p1 != 5'd0);

  logic tmo;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // tmo fires on the TIMEOUT-th consecutive WAIT cycle without data.
  assign tmo = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Count WAIT cycles without load data; cleared whenever a load enters WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (acc_load_p0) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !mem_rvalid && !tmo) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  // Without the timeout, a load waits in WAIT indefinitely.
  assign tmo            = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // ---- stage p2: write port and forwarding registers ----
  // Control FSM: accept, wait for load data, then commit one registered write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we3       <= 1'b0;
      r3        <= 5'd0;
      dw3       <= '0;
      fwd_valid <= 1'b0;
      fwd_rd    <= 5'd0;
      fwd_data  <= '0;
      err       <= 1'b0;
    end else begin
      we3 <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (accept_p0) begin
            if (acc_load_p0) begin
              state <= WAIT;
            end else begin
              state     <= COMMIT;
              we3       <= wr_p0;
              r3        <= in_rd;
              dw3       <= res_p0;
              fwd_valid <= wr_p0;
              fwd_rd    <= in_rd;
              fwd_data  <= res_p0;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // Data arriving on the timeout cycle wins over the abort.
          if (mem_rvalid) begin
            state     <= COMMIT;
            we3       <= ld_wr_p1;
            r3        <= ld_rd_p1;
            dw3       <= ld_data_p1;
            fwd_valid <= ld_wr_p1;
            fwd_rd    <= ld_rd_p1;
            fwd_data  <= ld_data_p1;
            err       <= ld_bad_p1;
          end else if (tmo) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes the expected write/error event,
// a monitor pops and compares whenever we3 or err is seen.
module tb_wb_stage;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [1:0]      in_src;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc4;
  logic [2:0]      in_funct3;
  logic [2:0]      in_off;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            we3;
  logic [4:0]      r3;
  logic [XLEN-1:0] dw3;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            err;

  wb_stage #(.XLEN(XLEN), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_src(in_src), .in_alu(in_alu), .in_pc4(in_pc4),
    .in_funct3(in_funct3), .in_off(in_off),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .we3(we3), .r3(r3), .dw3(dw3),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic            er;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  localparam logic [63:0] D = 64'hF1E2_D3C4_B5A6_9788;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [63:0] data);
    ev_t e;
    e.we = 1'b1; e.er = 1'b0; e.rd = rd; e.data = data;
    q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.we = 1'b0; e.er = 1'b1; e.rd = 5'd0; e.data = '0;
    q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (we3 || err)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 64'({we3, err}), 64'd0);
        end else begin
          e = q.pop_front();
          chk("event_kind", 64'({we3, err}), 64'({e.we, e.er}));
          if (e.we) begin
            chk("r3", 64'(r3), 64'(e.rd));
            chk("dw3", dw3, e.data);
            chk("fwd", 64'({fwd_valid, fwd_rd}), 64'({1'b1, e.rd}));
            chk("fwd_data", fwd_data, e.data);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] src,
                       input logic [63:0] alu, input logic [63:0] pc4,
                       input logic [2:0] f3, input logic [2:0] off);
    int   n;
    logic acc;
    in_valid  = 1'b1;
    in_rd     = rd;
    in_src    = src;
    in_alu    = alu;
    in_pc4    = pc4;
    in_funct3 = f3;
    in_off    = off;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic mem_resp(input int delay, input logic [63:0] data);
    tick(delay);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick(1);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                      input int delay, input logic [63:0] data);
    issue(rd, 2'b01, 64'd0, 64'd0, f3, off);
    chk("ready_in_wait", 64'(in_ready), 64'd0);
    mem_resp(delay, data);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_rd      = '0;
    in_src     = '0;
    in_alu     = '0;
    in_pc4     = '0;
    in_funct3  = '0;
    in_off     = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    fork
      monitor();
    join_none

    tick(2);
    chk("reset_ctrl", 64'({in_ready, we3, err, fwd_valid}), 64'b1000);
    chk("reset_addr", 64'({r3, fwd_rd}), 64'd0);
    chk("reset_data", dw3 | fwd_data, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // ALU op, one-cycle latency, then back to IDLE with forwarding held
    exp_wr(5'd5, 64'h1234);
    issue(5'd5, 2'b00, 64'h1234, 64'h0, 3'd0, 3'd0);
    chk("alu_latency", 64'({we3, r3}), 64'({1'b1, 5'd5}));
    chk("alu_dw3", dw3, 64'h1234);
    chk("ready_commit", 64'(in_ready), 64'd1);
    tick(1);
    chk("idle_after", 64'({in_ready, we3}), 64'b10);
    chk("fwd_hold", 64'({fwd_valid, fwd_rd, r3}), 64'({1'b1, 5'd5, 5'd5}));
    chk("fwd_hold_data", fwd_data, 64'h1234);

    // PC+4 and reserved source
    exp_wr(5'd9, 64'h0000_0000_8000_0004);
    issue(5'd9, 2'b10, 64'hDEAD, 64'h0000_0000_8000_0004, 3'd0, 3'd0);
    tick(1);
    exp_wr(5'd10, 64'h0BAD_F00D);
    issue(5'd10, 2'b11, 64'h0BAD_F00D, 64'h4, 3'd0, 3'd0);
    tick(1);

    // rd = 0: no write, no forwarding
    issue(5'd0, 2'b00, 64'hAAAA, 64'h0, 3'd0, 3'd0);
    chk("rd0_no_write", 64'({we3, fwd_valid, err}), 64'd0);
    tick(1);

    // Loads with hand-computed extraction
    exp_wr(5'd7, 64'hFFFF_FFFF_FFFF_FF80);
    load(5'd7, 3'b000, 3'd3, 4, 64'h0000_0000_8000_0000);
    chk("load_latency", 64'(we3), 64'd1);
    tick(1);
    exp_wr(5'd8, 64'h97);
    load(5'd8, 3'b100, 3'd1, 1, D);
    tick(1);
    exp_wr(5'd11, 64'hFFFF_FFFF_FFFF_B5A6);
    load(5'd11, 3'b001, 3'd2, 0, D);
    tick(1);
    exp_wr(5'd12, 64'h0000_0000_0000_F1E2);
    load(5'd12, 3'b101, 3'd6, 2, D);
    tick(1);
    exp_wr(5'd13, 64'hFFFF_FFFF_F1E2_D3C4);
    load(5'd13, 3'b010, 3'd4, 1, D);
    tick(1);
    exp_wr(5'd14, 64'h0000_0000_B5A6_9788);
    load(5'd14, 3'b110, 3'd0, 3, D);
    tick(1);
    exp_wr(5'd15, 64'h0000_0000_7FFF_FFFF);
    load(5'd15, 3'b010, 3'd0, 1, 64'hFFFF_FFFF_7FFF_FFFF);
    tick(1);

    // Fault cases: misaligned and reserved funct3
    exp_err();
    load(5'd4, 3'b101, 3'd1, 1, D);
    chk("lhu_misaligned", 64'({err, we3}), 64'b10);
    tick(1);
    chk("err_one_cycle", 64'(err), 64'd0);
    exp_err();
    load(5'd4, 3'b010, 3'd2, 0, D);
    tick(1);
    exp_err();
    load(5'd4, 3'b011, 3'd4, 0, D);
    tick(1);
    exp_err();
    load(5'd4, 3'b111, 3'd0, 0, D);
    tick(1);
    load(5'd0, 3'b000, 3'd0, 0, D);
    chk("load_rd0", 64'({we3, fwd_valid, err}), 64'd0);
    tick(1);

    // Back-to-back ALU ops, then load followed by ALU accepted in COMMIT
    exp_wr(5'd1, 64'h11);
    exp_wr(5'd2, 64'h22);
    exp_wr(5'd3, 64'h33);
    issue(5'd1, 2'b00, 64'h11, 64'h0, 3'd0, 3'd0);
    issue(5'd2, 2'b00, 64'h22, 64'h0, 3'd0, 3'd0);
    chk("b2b_second", 64'({we3, r3}), 64'({1'b1, 5'd2}));
    issue(5'd3, 2'b00, 64'h33, 64'h0, 3'd0, 3'd0);
    chk("b2b_third", 64'({we3, r3}), 64'({1'b1, 5'd3}));
    tick(1);
    exp_wr(5'd20, D);
    exp_wr(5'd21, 64'h55);
    load(5'd20, 3'b011, 3'd0, 2, D);
    issue(5'd21, 2'b00, 64'h55, 64'h0, 3'd0, 3'd0);
    chk("load_then_alu", 64'({we3, r3}), 64'({1'b1, 5'd21}));
    tick(2);

    // Reset during WAIT drops the load; later rvalid is ignored
    issue(5'd25, 2'b01, 64'd0, 64'd0, 3'b011, 3'd0);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ctrl", 64'({in_ready, we3, err, fwd_valid}), 64'b1000);
    chk("rst_wait_addr", 64'({r3, fwd_rd}), 64'd0);
    chk("rst_wait_data", dw3 | fwd_data, 64'd0);
    tick(1);
    rst_n = 1'b1;
    mem_resp(0, D);
    chk("rvalid_ignored", 64'({we3, err}), 64'd0);
    tick(2);

`ifdef WB_TIMEOUT_EN
    // Timeout after 8 WAIT cycles without data
    exp_err();
    issue(5'd6, 2'b01, 64'd0, 64'd0, 3'b000, 3'd0);
    n = 0;
    while (!err && n < 20) begin
      tick(1);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd8);
    chk("timeout_state", 64'({in_ready, we3}), 64'b10);
    tick(2);
`endif

    n = q.size();
    chk("queue_drained", 64'(n), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage that feeds the three-port register file write port (we3/r3/dw3).
- Accepts completed instructions from the memory stage over a valid/ready handshake.
- Selects the result source: ALU, load data, or PC+4.
- Waits for late load data, extends and aligns it, then issues exactly one registered write per instruction.

Parameters:
- XLEN, 64, datapath width; all data ports are XLEN bits.
- TIMEOUT, 255, maximum cycles spent in WAIT before aborting; used only when WB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  memory stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_rd  input  5  destination register.
- in_src  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- in_alu  input  XLEN  ALU result.
- in_pc4  input  XLEN  PC+4.
- in_funct3  input  3  load type.
- in_off  input  3  load byte offset (address[2:0]).
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  XLEN  doubleword containing the load data.
- we3  output  1  register file write enable.
- r3  output  5  register file write address.
- dw3  output  XLEN  register file write data.
- fwd_valid  output  1  a committed value is available for forwarding.
- fwd_rd  output  5  destination of the forwarded value.
- fwd_data  output  XLEN  forwarded value.
- err  output  1  one-cycle pulse: misaligned access, reserved funct3, or timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - we3, r3, dw3, fwd_valid, fwd_rd, fwd_data and err are all 0.
  - in_ready is 1.
  - Asserting rst_n low mid-operation drops any pending load and writes nothing.
- FSM states: IDLE, WAIT, COMMIT.
- in_ready = (state is IDLE or COMMIT). An instruction is accepted when in_valid and in_ready are both high on a rising edge.
- Accepting a non-load (in_src != 01) moves to COMMIT. Result is in_alu, or in_pc4 when in_src = 10.
- Accepting a load moves to WAIT and latches rd, funct3 and off.
- mem_rvalid is ignored outside WAIT.
- WAIT, mem_rvalid high: extract and extend the data, then move to COMMIT. mem_rvalid low: stay in WAIT.
- Load extraction (byte lane = off):
  - funct3 000 LB, 001 LH, 010 LW: sign-extend.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Load errors (write suppressed, err pulses in the COMMIT cycle):
  - Misaligned: LH/LHU with off[0]=1; LW/LWU with off[1:0]!=0; LD with off!=0.
  - funct3 111 is reserved.
- COMMIT lasts exactly one cycle.
  - we3 = 1 unless rd = 0 or an error is flagged.
  - r3 and dw3 are driven from registers, so they are stable for the whole cycle.
- Leaving COMMIT:
  - A new instruction accepted in COMMIT goes to COMMIT (non-load) or WAIT (load), giving back-to-back writes.
  - Otherwise the stage returns to IDLE.
- Latency:
  - Non-load: accept edge to we3 high is 1 cycle.
  - Load: 1 cycle after the mem_rvalid edge.
- Forwarding:
  - fwd_valid/fwd_rd/fwd_data equal we3/r3/dw3 during COMMIT.
  - After COMMIT they hold the last committed value with fwd_valid = 1, until the next COMMIT or reset.
  - fwd_valid is 0 when rd = 0.
- Outside COMMIT, we3 is 0; r3 and dw3 hold their last values.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT, go to IDLE, pulse err for one cycle, and do not write.
  - mem_rvalid arriving in the same cycle as the timeout wins: load completes normally.
- Not defined: no counter; WAIT waits indefinitely; err pulses only for misaligned/reserved cases.

Test Plan:
- ALU op, rd=5, in_alu=0x1234 -> next cycle we3=1, r3=5, dw3=0x1234; then in_ready=1 and the stage returns to IDLE.
- LB, off=3, rd=7, mem_rdata=0x00000000_80000000 after 4 WAIT cycles -> we3 pulse, r3=7, dw3=0xFFFFFFFF_FFFFFF80.
- LHU off=1 -> err pulse, we3=0.
- Non-load with rd=0 -> we3=0, fwd_valid=0.
- Back-to-back ALU ops rd=1,2,3 held valid -> three consecutive we3 cycles in order.
- Assert rst_n low during WAIT -> outputs 0, no write, and a later mem_rvalid is ignored.
- With WB_TIMEOUT_EN, TIMEOUT=8 and no rvalid -> err pulse after 8 WAIT cycles, we3=0, state IDLE.
